// File: rtl/muldiv_seq_if.sv
// Handshake bundle between the execute stage and the multiply/divide unit.
// Latency: n/a (signal bundle only).
// Backpressure: the requester holds off while ready_o is low; no queuing behind it.
// Ports: start_i/fun3_i/rs1_i/rs2_i/flush_i toward the unit; ready_o/busy_o/valid_o/result_o back.
interface muldiv_seq_if #(
  parameter int XLEN = 32
);
  logic            start_i;
  logic [2:0]      fun3_i;
  logic [XLEN-1:0] rs1_i;
  logic [XLEN-1:0] rs2_i;
  logic            flush_i;
  logic            ready_o;
  logic            busy_o;
  logic            valid_o;
  logic [XLEN-1:0] result_o;

  // Pipeline side drives the request and reads status/result.
  modport master (
    output start_i, fun3_i, rs1_i, rs2_i, flush_i,
    input  ready_o, busy_o, valid_o, result_o
  );

  // Unit side.
  modport slave (
    input  start_i, fun3_i, rs1_i, rs2_i, flush_i,
    output ready_o, busy_o, valid_o, result_o
  );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative RV32M/RV64M multiply/divide unit (shift-add multiply, restoring divide).
// Latency: valid_o XLEN+1 cycles after accept; 1 cycle for div-by-zero/overflow when FAST_SPECIAL.
// Backpressure: accepts only while ready_o=1 (IDLE); start_i otherwise ignored, flush_i aborts.
// Ports: clk, reset (sync, active-high); bus (muldiv_seq_if.slave) carries request, status and result.
module muldiv_seq #(
  parameter int  XLEN         = 32,
  parameter bit  FAST_SPECIAL = 1'b1,
  localparam int CNT_W        = $clog2(XLEN + 1)
) (
  input logic         clk,
  input logic         reset,
  muldiv_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t              state_q, state_d;
  logic [2:0]          op_q;
  logic [XLEN-1:0]     opd_q;       // multiplicand (mul) or divisor magnitude (div)
  logic [2*XLEN-1:0]   acc_q;       // mul: {partial hi, multiplier}; div: {remainder, dividend/quotient}
  logic                neg_main_q;  // negate product / quotient
  logic                neg_rem_q;   // negate remainder
  logic                spec_q;
  logic [XLEN-1:0]     spec_res_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [XLEN-1:0]     result_q;

  logic                rdy, bsy, fire, accept;

  // ---------------- request decode (only meaningful at acceptance) ----------------
  logic            rs1_signed, rs2_signed, s1, s2, is_div;
  logic            div_zero, sovf, special;
  logic [XLEN-1:0] mag1, mag2, spec_res;

  always_comb begin
    rs1_signed = (bus.fun3_i == 3'b001) || (bus.fun3_i == 3'b010) ||
                 (bus.fun3_i == 3'b100) || (bus.fun3_i == 3'b110);
    rs2_signed = (bus.fun3_i == 3'b001) || (bus.fun3_i == 3'b100) ||
                 (bus.fun3_i == 3'b110);
    s1         = rs1_signed & bus.rs1_i[XLEN-1];
    s2         = rs2_signed & bus.rs2_i[XLEN-1];
    mag1       = s1 ? -bus.rs1_i : bus.rs1_i;
    mag2       = s2 ? -bus.rs2_i : bus.rs2_i;
    is_div     = bus.fun3_i[2];
    div_zero   = is_div && (bus.rs2_i == '0);
    // Only DIV/REM (fun3[0]=0 within the divide group) can overflow.
    sovf       = is_div && !bus.fun3_i[0] && (bus.rs1_i == MOST_NEG) && (bus.rs2_i == '1);
    special    = div_zero || sovf;
    // fun3[1] distinguishes remainder from quotient.
    if (div_zero) spec_res = bus.fun3_i[1] ? bus.rs1_i : '1;
    else          spec_res = bus.fun3_i[1] ? '0 : bus.rs1_i;
  end

  // ---------------- one iteration of the datapath ----------------
  logic [XLEN-1:0]   acc_hi, acc_lo;
  logic [XLEN:0]     mul_sum, sh_rem, div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] mul_next, div_next;

  assign acc_hi   = acc_q[2*XLEN-1:XLEN];
  assign acc_lo   = acc_q[XLEN-1:0];

  // Multiply: add multiplicand when the current multiplier bit is set, then
  // shift the whole accumulator right; the carry enters the top bit.
  assign mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opd_q} : '0);
  assign mul_next = {mul_sum, acc_lo[XLEN-1:1]};

  // Restoring divide: shift the next dividend bit into the remainder and keep
  // the difference only when it does not go negative.
  assign sh_rem   = {acc_hi, acc_lo[XLEN-1]};
  assign div_diff = sh_rem - {1'b0, opd_q};
  assign div_ge   = ~div_diff[XLEN];
  assign div_next = {(div_ge ? div_diff[XLEN-1:0] : sh_rem[XLEN-1:0]),
                     acc_lo[XLEN-2:0], div_ge};

  // ---------------- sign correction and result select ----------------
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, final_res;

  assign prod = neg_main_q ? -acc_q  : acc_q;
  assign quo  = neg_main_q ? -acc_lo : acc_lo;
  assign rem  = neg_rem_q  ? -acc_hi : acc_hi;

  always_comb begin
    final_res = '0;
    case (op_q)
      3'b000:                 final_res = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: final_res = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         final_res = quo;
      default:                final_res = rem;
    endcase
    // Special results override whatever the iterations produced.
    if (spec_q) final_res = spec_res_q;
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    rdy     = 1'b0;
    bsy     = 1'b0;
    fire    = 1'b0;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        rdy = 1'b1;
        if (bus.start_i && !bus.flush_i) begin
          accept  = 1'b1;
          state_d = (FAST_SPECIAL && special) ? DONE : CALC;
        end
      end
      CALC: begin
        bsy = 1'b1;
        if (cnt_q == CNT_W'(XLEN - 1)) state_d = DONE;
      end
      DONE: begin
        fire    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Redirect wins everywhere and swallows a pending result.
    if (bus.flush_i) begin
      state_d = IDLE;
      fire    = 1'b0;
    end
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q       <= '0;
      opd_q      <= '0;
      acc_q      <= '0;
      neg_main_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      spec_q     <= 1'b0;
      spec_res_q <= '0;
      cnt_q      <= '0;
      result_q   <= '0;
    end else begin
      if (accept) begin
        op_q       <= bus.fun3_i;
        opd_q      <= is_div ? mag2 : mag1;
        acc_q      <= {{XLEN{1'b0}}, (is_div ? mag1 : mag2)};
        neg_main_q <= s1 ^ s2;
        neg_rem_q  <= s1;
        spec_q     <= special;
        spec_res_q <= spec_res;
        cnt_q      <= '0;
      end else if (state_q == CALC) begin
        acc_q <= op_q[2] ? div_next : mul_next;
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (fire) result_q <= final_res;
    end
  end

  assign bus.ready_o  = rdy;
  assign bus.busy_o   = bsy;
  assign bus.valid_o  = fire;
  // The fresh result is visible during the valid pulse, then held from result_q.
  assign bus.result_o = fire ? final_res : result_q;

endmodule
